// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 2-D convolution engine.
package conv_pkg;

  localparam int unsigned PIPE_LAT = 2;
  localparam int unsigned WORD_W   = 16;

  typedef logic [WORD_W-1:0] word_t;

  // Result width that can hold K*K full-width products without overflow.
  function automatic int unsigned conv_ow(input int unsigned dw, input int unsigned k);
    return 2 * dw + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row line buffer: one long shift register advanced on every accepted pixel.
module conv_line_buffer #(
  parameter int unsigned IMG_W = 5,
  parameter int unsigned K     = 3,
  parameter int unsigned DW    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  input  logic [DW-1:0]           pix_i,
  // tap_o[i] is the pixel i+1 rows above pix_i, same column.
  output logic [K-2:0][DW-1:0]    tap_o
);

  localparam int unsigned Depth = (K - 1) * IMG_W;

  logic [DW-1:0] buf_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        buf_q[i] <= '0;
      end
    end else if (valid_i) begin
      buf_q[0] <= pix_i;
      for (int i = 1; i < Depth; i++) begin
        buf_q[i] <= buf_q[i-1];
      end
    end
  end

  for (genvar i = 0; i < K - 1; i++) begin : g_tap
    assign tap_o[i] = buf_q[(i+1)*IMG_W-1];
  end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming KxK valid-padding convolution with a two-stage multiply / sum pipeline.
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = 5,
  parameter int unsigned IMG_H  = 5,
  parameter int unsigned K      = 3,
  parameter int unsigned DW     = 16,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned OW     = conv_ow(DW, K)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          weight_valid,
  input  logic [DW-1:0] in_weight,
  input  logic          in_valid,
  input  logic [DW-1:0] in_ifm,
  output logic          out_valid,
  output logic [OW-1:0] out_ofm,
  output logic          out_last
);

  localparam int unsigned Taps = K * K;
  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam int unsigned WcW  = $clog2(Taps);
  localparam int unsigned ExtW = OW - 2 * DW;

  localparam logic [ColW-1:0] ColLast  = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(K - 1);
  localparam logic [RowW-1:0] RowFirst = RowW'(K - 1);
  localparam logic [WcW-1:0]  WcLast   = WcW'(Taps - 1);

  // ---------------------------------------------------------------- weights
  logic [DW-1:0]  w_q [Taps];
  logic [WcW-1:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = '0;
    if (weight_valid) begin
      wcnt_d = (wcnt_q == WcLast) ? wcnt_q : wcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      for (int t = 0; t < Taps; t++) begin
        w_q[t] <= '0;
      end
    end else begin
      wcnt_q <= wcnt_d;
      if (weight_valid) begin
        w_q[wcnt_q] <= in_weight;
      end
    end
  end

  // ---------------------------------------------------------- pixel counters
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            win_valid, win_last;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign win_valid = in_valid && (row_q >= RowFirst) && (col_q >= ColFirst);
  assign win_last  = (row_q == RowLast) && (col_q == ColLast);

  // ------------------------------------------------------------------ window
  logic [K-2:0][DW-1:0]         lb_tap;
  logic [K-1:0][DW-1:0]         col_vec;
  logic [K-1:0][K-2:0][DW-1:0]  hist_q;

  conv_line_buffer #(
    .IMG_W (IMG_W),
    .K     (K),
    .DW    (DW)
  ) u_line_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (in_valid),
    .pix_i   (in_ifm),
    .tap_o   (lb_tap)
  );

  // Row K-1 is the current pixel; row 0 is K-1 lines above it.
  assign col_vec[K-1] = in_ifm;
  for (genvar r = 0; r < K - 1; r++) begin : g_colvec
    assign col_vec[r] = lb_tap[K-2-r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else if (in_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 2; c++) begin
          hist_q[r][c] <= hist_q[r][c+1];
        end
        hist_q[r][K-2] <= col_vec[r];
      end
    end
  end

  // -------------------------------------------------------------- S0: multiply
  logic [Taps-1:0][2*DW-1:0] prod_d, prod_q;
  logic                      s0_valid_q, s0_last_q;

  for (genvar t = 0; t < Taps; t++) begin : g_mul
    localparam int unsigned R = t / K;
    localparam int unsigned C = t % K;
    logic [DW-1:0]   pix;
    logic [2*DW-1:0] pix_x, wt_x;

    if (C == K - 1) begin : g_cur
      assign pix = col_vec[R];
    end else begin : g_hist
      assign pix = hist_q[R][C];
    end

    // Extending to 2*DW first makes the truncated product exact in both modes.
    assign pix_x     = SIGNED ? {{DW{pix[DW-1]}}, pix} : {{DW{1'b0}}, pix};
    assign wt_x      = SIGNED ? {{DW{w_q[t][DW-1]}}, w_q[t]} : {{DW{1'b0}}, w_q[t]};
    assign prod_d[t] = pix_x * wt_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q     <= '0;
      s0_valid_q <= 1'b0;
      s0_last_q  <= 1'b0;
    end else begin
      if (win_valid) begin
        prod_q <= prod_d;
      end
      s0_valid_q <= win_valid;
      s0_last_q  <= win_last;
    end
  end

  // ------------------------------------------------------------------ S1: sum
  logic [Taps-1:0][OW-1:0] prod_x;
  logic [OW-1:0]           sum_d;

  for (genvar t = 0; t < Taps; t++) begin : g_ext
    assign prod_x[t] = SIGNED ? {{ExtW{prod_q[t][2*DW-1]}}, prod_q[t]}
                              : {{ExtW{1'b0}}, prod_q[t]};
  end

  always_comb begin
    sum_d = '0;
    for (int t = 0; t < Taps; t++) begin
      sum_d = sum_d + prod_x[t];
    end
  end

  logic          out_valid_q, out_last_q;
  logic [OW-1:0] out_ofm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ofm_q   <= '0;
    end else begin
      out_valid_q <= s0_valid_q;
      out_last_q  <= s0_valid_q & s0_last_q;
      out_ofm_q   <= s0_valid_q ? sum_d : '0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ofm   = out_ofm_q;

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Scoreboard bench: three engine configurations checked against a direct window-sum model.
module tb_conv2d_stream_engine;
  import conv_pkg::*;

  typedef struct {
    longint val;
    bit     last;
    longint due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  wv, iv, ov, ol;
  logic [15:0] wd [3];
  logic [15:0] id [3];
  logic [36:0] oo [3];
  logic [35:0] oo0, oo1;
  logic [36:0] oo2;

  always #5 clk = ~clk;

  conv2d_stream_engine #(.IMG_W(5), .IMG_H(5), .K(3), .DW(16), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .weight_valid(wv[0]), .in_weight(wd[0]), .in_valid(iv[0]),
    .in_ifm(id[0]), .out_valid(ov[0]), .out_ofm(oo0), .out_last(ol[0])
  );
  conv2d_stream_engine #(.IMG_W(5), .IMG_H(5), .K(3), .DW(16), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .weight_valid(wv[1]), .in_weight(wd[1]), .in_valid(iv[1]),
    .in_ifm(id[1]), .out_valid(ov[1]), .out_ofm(oo1), .out_last(ol[1])
  );
  conv2d_stream_engine #(.IMG_W(8), .IMG_H(6), .K(5), .DW(16), .SIGNED(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .weight_valid(wv[2]), .in_weight(wd[2]), .in_valid(iv[2]),
    .in_ifm(id[2]), .out_valid(ov[2]), .out_ofm(oo2), .out_last(ol[2])
  );

  assign oo[0] = {1'b0, oo0};
  assign oo[1] = {1'b0, oo1};
  assign oo[2] = oo2;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  exp_t   exp_q[$];
  longint log_q[$];
  exp_t   mon_e;

  // Model state for the currently driven instance.
  int     act = 0;
  int     mw_ = 5, mh_ = 5, mk_ = 3, ow_ = 36;
  bit     ms_ = 1'b0;
  int     mrow = 0, mcol = 0, mwcnt = 0;
  longint mw [3][25];
  word_t  fpix [48];
  word_t  psrc [48];
  word_t  wsrc [32];
  longint t2_exp [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint a, input longint e);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, a, e, cyc);
    end
  endtask

  function automatic longint ext(input logic [15:0] v);
    if (ms_) return longint'($signed(v));
    return longint'(v);
  endfunction

  // Drive one cycle of inputs and record what the engine should produce for it.
  task automatic step(input bit wb, input word_t wdat, input bit pb, input word_t pdat);
    longint s;
    exp_t   e;
    wv[act] = wb;
    wd[act] = wdat;
    iv[act] = pb;
    id[act] = pdat;
    if (pb) begin
      fpix[mrow*mw_+mcol] = pdat;
      if (mrow >= mk_ - 1 && mcol >= mk_ - 1) begin
        s = 0;
        for (int i = 0; i < mk_; i++) begin
          for (int j = 0; j < mk_; j++) begin
            s += mw[act][i*mk_+j] * ext(fpix[(mrow-mk_+1+i)*mw_ + mcol-mk_+1+j]);
          end
        end
        e.val  = s & ((longint'(1) << ow_) - 1);
        e.last = (mrow == mh_ - 1) && (mcol == mw_ - 1);
        e.due  = cyc + PIPE_LAT;
        exp_q.push_back(e);
      end
      if (mcol == mw_ - 1) begin
        mcol = 0;
        mrow = (mrow == mh_ - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
    if (wb) begin
      mw[act][mwcnt] = ext(wdat);
      if (mwcnt < mk_ * mk_ - 1) mwcnt++;
    end else begin
      mwcnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  // Weights burst from cycle 0; pixels follow with random gaps up to gapmax.
  task automatic run_frame(input int gapmax, input int nw, input int npix);
    int pi  = 0;
    int wi  = 0;
    int gap = 0;
    bit wb, pb;
    while (pi < npix || wi < nw) begin
      wb = (wi < nw);
      pb = 1'b0;
      if (pi < npix) begin
        if (gap > 0) gap--;
        else pb = 1'b1;
      end
      step(wb, wb ? wsrc[wi] : '0, pb, pb ? psrc[pi] : '0);
      if (wb) wi++;
      if (pb) begin
        pi++;
        gap = int'($urandom_range(gapmax, 0));
      end
    end
  endtask

  task automatic select(input int g);
    idle(1);
    act  = g;
    mw_  = (g == 2) ? 8 : 5;
    mh_  = (g == 2) ? 6 : 5;
    mk_  = (g == 2) ? 5 : 3;
    ow_  = (g == 2) ? 37 : 36;
    ms_  = (g == 1);
    mrow = 0;
    mcol = 0;
    idle(2);
  endtask

  task automatic do_reset();
    wv = '0;
    iv = '0;
    rst_n = 1'b0;
    exp_q.delete();
    for (int g = 0; g < 3; g++) for (int t = 0; t < 25; t++) mw[g][t] = 0;
    mrow  = 0;
    mcol  = 0;
    mwcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic fill_rand(input int npix, input int nw);
    for (int i = 0; i < npix; i++) psrc[i] = word_t'($urandom);
    for (int i = 0; i < nw; i++) wsrc[i] = word_t'($urandom);
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ov[g]) begin
        if (g != act || exp_q.size() == 0) begin
          chk(1'b0, "unexpected_out", longint'(oo[g]), -1);
        end else begin
          mon_e = exp_q.pop_front();
          chk(longint'(oo[g]) == mon_e.val, "ofm", longint'(oo[g]), mon_e.val);
          chk(ol[g] == mon_e.last, "last", longint'(ol[g]), longint'(mon_e.last));
          chk(cyc == mon_e.due, "latency_cycle", cyc, mon_e.due);
          log_q.push_back(longint'(oo[g]));
        end
      end else begin
        chk(oo[g] == '0 && !ol[g], "idle_zero", longint'(oo[g]), 0);
      end
    end
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      chk(1'b0, "missing_out", cyc, exp_q[0].due);
      exp_q.delete(0);
    end
  end

  initial begin
    rst_n = 1'b0;
    wv = '0;
    iv = '0;
    for (int g = 0; g < 3; g++) begin
      wd[g] = '0;
      id[g] = '0;
      for (int t = 0; t < 25; t++) mw[g][t] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk(!ov[g] && !ol[g] && oo[g] == '0, "reset_state", longint'(oo[g]), 0);
    end
    rst_n = 1'b1;
    select(0);

    // All-ones frame: nine outputs of 9.
    for (int i = 0; i < 25; i++) psrc[i] = 16'd1;
    for (int i = 0; i < 9; i++) wsrc[i] = 16'd1;
    log_q.delete();
    run_frame(0, 9, 25);
    idle(4);
    chk(log_q.size() == 9, "ones_count", log_q.size(), 9);
    foreach (log_q[i]) chk(log_q[i] == 9, "ones_value", log_q[i], 9);

    // Ramp with a centre-only kernel picks out the window centre.
    for (int i = 0; i < 25; i++) psrc[i] = word_t'(i);
    for (int i = 0; i < 9; i++) wsrc[i] = (i == 4) ? 16'd1 : 16'd0;
    log_q.delete();
    run_frame(0, 9, 25);
    idle(4);
    chk(log_q.size() == 9, "centre_count", log_q.size(), 9);
    foreach (log_q[i]) if (i < 9) chk(log_q[i] == t2_exp[i], "centre_value", log_q[i], t2_exp[i]);

    // Full-scale operands must not wrap.
    for (int i = 0; i < 25; i++) psrc[i] = 16'hFFFF;
    for (int i = 0; i < 9; i++) wsrc[i] = 16'hFFFF;
    log_q.delete();
    run_frame(0, 9, 25);
    idle(4);
    chk(log_q.size() == 9, "max_count", log_q.size(), 9);
    foreach (log_q[i]) chk(log_q[i] == 64'h8_FFEE_0009, "max_value", log_q[i], 64'h8_FFEE_0009);

    // Random data with gaps; over-long weight burst, then a frame reusing the weights.
    fill_rand(25, 11);
    run_frame(3, 11, 25);
    fill_rand(25, 0);
    run_frame(3, 0, 25);
    idle(4);

    // Reset after 13 pixels drops the in-flight window; a full new frame follows.
    fill_rand(13, 9);
    run_frame(0, 9, 13);
    do_reset();
    fill_rand(25, 9);
    log_q.delete();
    run_frame(1, 9, 25);
    idle(4);
    chk(log_q.size() == 9, "post_reset_count", log_q.size(), 9);

    // Signed mode: -1 pixels, unit weights give -9, then random signed data.
    select(1);
    for (int i = 0; i < 25; i++) psrc[i] = 16'hFFFF;
    for (int i = 0; i < 9; i++) wsrc[i] = 16'd1;
    log_q.delete();
    run_frame(0, 9, 25);
    idle(4);
    chk(log_q.size() == 9, "signed_count", log_q.size(), 9);
    foreach (log_q[i]) chk(log_q[i] == 64'hF_FFFF_FFF7, "signed_value", log_q[i], 64'hF_FFFF_FFF7);
    fill_rand(25, 9);
    run_frame(2, 9, 25);
    idle(4);

    // 8x6 map with a 5x5 kernel.
    select(2);
    fill_rand(48, 25);
    log_q.delete();
    run_frame(2, 25, 48);
    idle(4);
    chk(log_q.size() == 8, "big_count", log_q.size(), 8);

    idle(4);
    chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
